// File: rtl/button_pulse_bank_pkg.sv
// Shared constants for the push-button conditioning bank: button indices,
// channel count, default timing and a small helper used to size counters.
package button_pulse_bank_pkg;

   localparam int BTN_U    = 0;
   localparam int BTN_D    = 1;
   localparam int BTN_L    = 2;
   localparam int BTN_R    = 3;
   localparam int BTN_C    = 4;
   localparam int NUM_BTNS = 5;

   // Defaults assume a 24.4 kHz game-logic clock.
   localparam int DEF_DEBOUNCE_CYCLES = 244;
   localparam int DEF_REPEAT_DELAY    = 12200;
   localparam int DEF_REPEAT_PERIOD   = 3660;

   function automatic int maxOf3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/button_pulse_bank_channel.sv
// One button channel: 2-flop synchronizer, stability-count debounce,
// registered press pulse and, when BTN_AUTOREPEAT_EN is defined and the
// channel allows it, a hold counter that issues auto-repeat pulses.
module btn_channel
   import button_pulse_bank_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
   parameter bit REPEAT_ALLOWED  = 1'b1
) (
   input  logic i_clk,
   input  logic i_resetN,
   input  logic i_btnRaw,
   output logic o_pulse,
   output logic o_level
);

   localparam int CntW = $clog2(maxOf3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD) + 1);
   localparam logic [CntW-1:0] DebLast = CntW'(DEBOUNCE_CYCLES - 1);

   logic            r_s1;
   logic            r_s2;
   logic            r_st;
   logic            r_stPrev;
   logic            r_pulse;
   logic [CntW-1:0] r_cnt;
   logic            w_accept;
   logic            w_rise;
   logic            w_repeatPulse;

   // The synchronized level has differed from the accepted one long enough.
   assign w_accept = (r_s2 != r_st) && (r_cnt == DebLast);
   assign w_rise   = r_st & ~r_stPrev;

   // Bring the asynchronous button into the clock domain.
   always_ff @(posedge i_clk) begin
      if (!i_resetN) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
      end else begin
         r_s1 <= i_btnRaw;
         r_s2 <= r_s1;
      end
   end

   // Accept a new level only after it has been stable for the full count.
   always_ff @(posedge i_clk) begin
      if (!i_resetN) begin
         r_st  <= 1'b0;
         r_cnt <= '0;
      end else if (r_s2 == r_st) begin
         r_cnt <= '0;
      end else if (w_accept) begin
         r_st  <= r_s2;
         r_cnt <= '0;
      end else if (r_cnt != '1) begin
         r_cnt <= r_cnt + CntW'(1);
      end
   end

   // One-cycle pulse after an accepted press, or on an auto-repeat tick.
   always_ff @(posedge i_clk) begin
      if (!i_resetN) begin
         r_stPrev <= 1'b0;
         r_pulse  <= 1'b0;
      end else begin
         r_stPrev <= r_st;
         r_pulse  <= w_rise | w_repeatPulse;
      end
   end

`ifdef BTN_AUTOREPEAT_EN
   generate
      if (REPEAT_ALLOWED) begin : g_repeat
         localparam logic [CntW-1:0] DelayLast  = CntW'(REPEAT_DELAY - 1);
         localparam logic [CntW-1:0] PeriodLast = CntW'(REPEAT_PERIOD - 1);

         logic [CntW-1:0] r_hc;
         logic            r_repeating;

         // First tick waits the long delay, later ticks the shorter period;
         // a release being accepted this cycle suppresses the tick.
         assign w_repeatPulse = r_st && !w_rise && !w_accept &&
                                (r_hc == (r_repeating ? PeriodLast : DelayLast));

         // Hold counter restarts on each press and on every repeat tick.
         always_ff @(posedge i_clk) begin
            if (!i_resetN) begin
               r_hc        <= '0;
               r_repeating <= 1'b0;
            end else if (!r_st || w_accept || w_rise) begin
               r_hc        <= '0;
               r_repeating <= 1'b0;
            end else if (w_repeatPulse) begin
               r_hc        <= '0;
               r_repeating <= 1'b1;
            end else if (r_hc != '1) begin
               r_hc <= r_hc + CntW'(1);
            end
         end
      end else begin : g_noRepeat
         assign w_repeatPulse = 1'b0;
      end
   endgenerate
`else
   // No hold counter in this build, so the channel never repeats.
   assign w_repeatPulse = 1'b0 & REPEAT_ALLOWED;
`endif

   assign o_pulse = r_pulse;
   assign o_level = r_st;

endmodule

// File: rtl/button_pulse_bank.sv
// Five-button conditioning bank feeding the chess game logic. Each raw
// button becomes one clean single-cycle pulse per press; BTN_AUTOREPEAT_EN
// adds auto-repeat on the U/D/L/R cursor buttons (never on C).
module button_pulse_bank
   import button_pulse_bank_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input  logic                CLK,
   input  logic                RESET_N,
   input  logic                BtnU,
   input  logic                BtnD,
   input  logic                BtnL,
   input  logic                BtnR,
   input  logic                BtnC,
   output logic                BtnU_pulse,
   output logic                BtnD_pulse,
   output logic                BtnL_pulse,
   output logic                BtnR_pulse,
   output logic                BtnC_pulse,
   output logic [NUM_BTNS-1:0] btn_state
);

   logic [NUM_BTNS-1:0] w_raw;
   logic [NUM_BTNS-1:0] w_pulse;

   assign w_raw = {BtnC, BtnR, BtnL, BtnD, BtnU};

   generate
      for (genvar i = 0; i < NUM_BTNS; i++) begin : g_chan
         btn_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .REPEAT_ALLOWED  (i != BTN_C)
         ) u_chan (
            .i_clk    (CLK),
            .i_resetN (RESET_N),
            .i_btnRaw (w_raw[i]),
            .o_pulse  (w_pulse[i]),
            .o_level  (btn_state[i])
         );
      end
   endgenerate

   assign BtnU_pulse = w_pulse[BTN_U];
   assign BtnD_pulse = w_pulse[BTN_D];
   assign BtnL_pulse = w_pulse[BTN_L];
   assign BtnR_pulse = w_pulse[BTN_R];
   assign BtnC_pulse = w_pulse[BTN_C];

endmodule

// File: tb/tb_button_pulse_bank.sv
// Self-checking bench for button_pulse_bank with short timing parameters.
// Follows BTN_AUTOREPEAT_EN to decide whether repeat pulses are expected.
module tb_button_pulse_bank;
   import button_pulse_bank_pkg::*;

   localparam int DEB  = 4;
   localparam int RDEL = 20;
   localparam int RPER = 6;
   localparam int MAXE = 2048;
`ifdef BTN_AUTOREPEAT_EN
   localparam bit RepeatOn = 1'b1;
`else
   localparam bit RepeatOn = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rstN = 1'b0;
   logic       btnU = 1'b0, btnD = 1'b0, btnL = 1'b0, btnR = 1'b0, btnC = 1'b0;
   logic       pU, pD, pL, pR, pC;
   logic [4:0] btnState;

   int checks = 0;
   int errors = 0;
   int edgeNum = 0;

   bit         stA    [5][0:MAXE-1];
   bit         rawEff [5][0:MAXE-1];
   bit         isRst  [0:MAXE-1];
   int         lastEvent [5];
   int         pressEdge [5];
   logic [4:0] expPulse = '0;
   logic [4:0] expState = '0;

   button_pulse_bank #(
      .DEBOUNCE_CYCLES (DEB),
      .REPEAT_DELAY    (RDEL),
      .REPEAT_PERIOD   (RPER)
   ) dut (
      .CLK        (clk),
      .RESET_N    (rstN),
      .BtnU       (btnU),
      .BtnD       (btnD),
      .BtnL       (btnL),
      .BtnR       (btnR),
      .BtnC       (btnC),
      .BtnU_pulse (pU),
      .BtnD_pulse (pD),
      .BtnL_pulse (pL),
      .BtnR_pulse (pR),
      .BtnC_pulse (pC),
      .btn_state  (btnState)
   );

   always #5 clk = ~clk;

   // Level seen by the debouncer just before edge m: raw input delayed two edges.
   function automatic bit s2Pre(input int b, input int m);
      if (m < 2) return 1'b0;
      if (isRst[m-1]) return 1'b0;
      if (m - 2 < 1) return 1'b0;
      return rawEff[b][m-2];
   endfunction

   function automatic bit stAt(input int b, input int e);
      if (e < 1) return 1'b0;
      return stA[b][e];
   endfunction

   // Reference model: a level is accepted once DEB consecutive synchronized
   // samples (all after the last change or reset) disagree with it.
   always @(posedge clk) begin
      logic [4:0] raw;
      edgeNum = edgeNum + 1;
      if (edgeNum >= MAXE) begin
         $display("[TB] FAIL modelRange: edge %0d beyond model storage %0d", edgeNum, MAXE);
         $fatal(1, "[TB] model storage exhausted");
      end
      raw = {btnC, btnR, btnL, btnD, btnU};
      isRst[edgeNum] = !rstN;
      for (int b = 0; b < 5; b++) begin
         rawEff[b][edgeNum] = rstN ? raw[b] : 1'b0;
         if (!rstN) begin
            stA[b][edgeNum] = 1'b0;
            lastEvent[b]    = edgeNum;
            expPulse[b]     = 1'b0;
         end else begin
            bit cur, flip, press, rep;
            int d;
            cur  = stAt(b, edgeNum - 1);
            flip = 1'b1;
            for (int m = edgeNum - DEB + 1; m <= edgeNum; m++)
               if (m <= lastEvent[b] || s2Pre(b, m) == cur) flip = 1'b0;
            stA[b][edgeNum] = flip ? !cur : cur;
            if (flip) lastEvent[b] = edgeNum;
            press = stAt(b, edgeNum - 1) && !stAt(b, edgeNum - 2);
            if (press) pressEdge[b] = edgeNum;
            rep = 1'b0;
            d   = edgeNum - pressEdge[b];
            if (RepeatOn && b != BTN_C && !press && pressEdge[b] > 0 &&
                stAt(b, edgeNum) && stAt(b, edgeNum - 1) &&
                d >= RDEL && ((d - RDEL) % RPER) == 0)
               rep = 1'b1;
            expPulse[b] = press | rep;
         end
         expState[b] = stA[b][edgeNum];
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks = checks + 1;
      if (actual !== expected) begin
         errors = errors + 1;
         $display("[TB] FAIL %s: got %0h expected %0h (edge %0d)", name, actual, expected, edgeNum);
      end
   endtask

   // Compare every output against the model once per cycle, on the falling edge.
   always @(negedge clk) begin
      if (edgeNum >= 1) begin
         checkOutput("modelPulses", {27'd0, pC, pR, pL, pD, pU}, {27'd0, expPulse});
         checkOutput("modelState", {27'd0, btnState}, {27'd0, expState});
      end
   end

   task automatic applyStimulus(input logic u, input logic d, input logic l,
                                input logic r, input logic c);
      @(negedge clk);
      btnU = u; btnD = d; btnL = l; btnR = r; btnC = c;
   endtask

   task automatic stepEdge;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) stepEdge();
   endtask

   initial begin
      int cnt;
      for (int b = 0; b < 5; b++) begin
         lastEvent[b] = 0;
         pressEdge[b] = 0;
      end

      // Reset state
      rstN = 1'b0;
      idle(3);
      checkOutput("resetPulses", {27'd0, pC, pR, pL, pD, pU}, 32'd0);
      checkOutput("resetState", {27'd0, btnState}, 32'd0);
      rstN = 1'b1;
      idle(4);

      // Clean press on U
      applyStimulus(1, 0, 0, 0, 0);
      for (int e = 1; e <= 12; e++) begin
         stepEdge();
         if (e == 5) checkOutput("cleanStateE5", {31'd0, btnState[0]}, 32'd0);
         if (e == 6) checkOutput("cleanStateE6", {31'd0, btnState[0]}, 32'd1);
         if (e == 6) checkOutput("cleanPulseE6", {31'd0, pU}, 32'd0);
         if (e == 7) checkOutput("cleanPulseE7", {31'd0, pU}, 32'd1);
         if (e == 8) checkOutput("cleanPulseE8", {31'd0, pU}, 32'd0);
      end
      applyStimulus(0, 0, 0, 0, 0);
      idle(15);

      // Bounce on L: 1,0,1,0 then held
      applyStimulus(0, 0, 1, 0, 0);
      cnt = 0;
      for (int e = 1; e <= 20; e++) begin
         stepEdge();
         if (pL) cnt++;
         if (e == 10) checkOutput("bouncePulseE10", {31'd0, pL}, 32'd0);
         if (e == 11) checkOutput("bouncePulseE11", {31'd0, pL}, 32'd1);
         if (e == 1 || e == 3) btnL = 1'b0;
         if (e == 2) btnL = 1'b1;
         if (e == 4) btnL = 1'b1;
      end
      checkOutput("bounceCount", cnt, 32'd1);
      applyStimulus(0, 0, 0, 0, 0);
      idle(15);

      // Simultaneous C and R
      applyStimulus(0, 0, 0, 1, 1);
      for (int e = 1; e <= 10; e++) begin
         stepEdge();
         if (e == 6) checkOutput("simulE6", {30'd0, pC, pR}, 32'd0);
         if (e == 7) checkOutput("simulE7", {30'd0, pC, pR}, 32'd3);
         if (e == 8) checkOutput("simulE8", {30'd0, pC, pR}, 32'd0);
      end
      applyStimulus(0, 0, 0, 0, 0);
      idle(15);

      // Reset in the middle of a D debounce count
      applyStimulus(0, 1, 0, 0, 0);
      for (int e = 1; e <= 16; e++) begin
         stepEdge();
         if (e >= 4 && e <= 6) begin
            checkOutput("rstMidPulses", {27'd0, pC, pR, pL, pD, pU}, 32'd0);
            checkOutput("rstMidState", {27'd0, btnState}, 32'd0);
         end
         if (e == 7)  checkOutput("rstMidNoEarly", {31'd0, pD}, 32'd0);
         if (e == 12) checkOutput("rstMidPulseE12", {31'd0, pD}, 32'd0);
         if (e == 13) checkOutput("rstMidPulseE13", {31'd0, pD}, 32'd1);
         if (e == 3) rstN = 1'b0;
         if (e == 6) rstN = 1'b1;
      end
      applyStimulus(0, 0, 0, 0, 0);
      idle(15);

      // Long hold on R: repeats when compiled in
      applyStimulus(0, 0, 0, 1, 0);
      cnt = 0;
      for (int e = 1; e <= 75; e++) begin
         stepEdge();
         if (pR) cnt++;
         if (e == 27) checkOutput("repeatFirstE27", {31'd0, pR}, {31'd0, RepeatOn});
         if (e == 33) checkOutput("repeatSecondE33", {31'd0, pR}, {31'd0, RepeatOn});
         if (e == 65) checkOutput("releaseStateE65", {31'd0, btnState[BTN_R]}, 32'd1);
         if (e == 66) checkOutput("releaseStateE66", {31'd0, btnState[BTN_R]}, 32'd0);
         if (e == 60) btnR = 1'b0;
      end
      checkOutput("repeatCountR", cnt, RepeatOn ? 32'd8 : 32'd1);
      idle(10);

      // Long hold on C: never repeats
      applyStimulus(0, 0, 0, 0, 1);
      cnt = 0;
      for (int e = 1; e <= 75; e++) begin
         stepEdge();
         if (pC) cnt++;
         if (e == 60) btnC = 1'b0;
      end
      checkOutput("repeatCountC", cnt, 32'd1);
      idle(10);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
